// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline front end.
//   - NOP_INSTR_C / RESET_PC_C : default bubble encoding and reset PC
//   - fetch_state_e            : IF-stage request FSM states
//   - ifid_t                   : contents of the IF/ID pipeline register
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

  // FETCH: may issue a request; WAIT: one request outstanding;
  // HELD: response parked in the skid buffer while decode is stalled.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.instr   = nop;
    b.pc      = 32'h0;
    b.pcplus4 = 32'h0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_fetchff.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_stall     : hold current contents
//   i_flush     : replace contents with a bubble (wins over stall and load)
//   i_load      : capture i_data as a real instruction
//   i_data      : instruction / PC / PC+4 to capture
//   o_q, o_valid: register contents and real-instruction flag
module fetchff
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_stall,
  input  logic  i_flush,
  input  logic  i_load,
  input  ifid_t i_data,
  output ifid_t o_q,
  output logic  o_valid
);

  ifid_t r_q;
  logic  r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= ifid_bubble(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_q     <= ifid_bubble(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_stall) begin
      r_q     <= r_q;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_q     <= i_data;
      r_valid <= 1'b1;
    end else begin
      // Nothing arrived this cycle: decode sees a bubble rather than a repeat.
      r_q     <= ifid_bubble(NOP_INSTR);
      r_valid <= 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, single-outstanding instruction
// memory handshake, one-entry skid buffer and IF/ID register.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   StallF, StallD, FlushD  : hazard unit controls
//   PCSrcE, PCTargetE       : redirect from execute
//   ImemReq, ImemAddr       : request to instruction memory (addr = PCF)
//   ImemValid, ImemRData    : response from instruction memory
//   InstrD, PCD, PCPlus4D   : IF/ID contents for decode
//   ValidD                  : 1 = InstrD is real, 0 = bubble
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_discard, w_discard_nxt;
  logic [31:0]  r_skid;
  logic         w_skid_we;
  logic         w_req;
  logic         w_load;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  ifid_t        w_ifid_d, w_ifid_q;

  assign w_pc_plus4 = r_pc + 32'd4;            // wraps modulo 2^32
  assign w_target   = PCTargetE & ~32'h0000_0003;

  assign w_req    = (r_state == FETCH) && !StallF && rst_n;
  assign ImemReq  = w_req;
  assign ImemAddr = r_pc;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_skid_we     = 1'b0;
    w_load        = 1'b0;
    w_load_instr  = ImemRData;

    unique case (r_state)
      FETCH: begin
        if (w_req) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (ImemValid) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = FETCH;
          end else if (!StallD) begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = FETCH;
          end else begin
            w_skid_we   = 1'b1;
            w_state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (!StallD) begin
          w_load       = 1'b1;
          w_load_instr = r_skid;
          w_pc_nxt     = w_pc_plus4;
          w_state_nxt  = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase

    // Redirect wins over everything above: nothing from the old path may
    // reach IF/ID, and a request already in flight is marked for discard.
    if (PCSrcE) begin
      w_pc_nxt  = w_target;
      w_load    = 1'b0;
      w_skid_we = 1'b0;
      unique case (r_state)
        FETCH: begin
          if (w_req) begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = WAIT;
          end else begin
            w_state_nxt   = FETCH;
          end
        end
        WAIT: begin
          if (ImemValid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = FETCH;
          end else begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = WAIT;
          end
        end
        default: w_state_nxt = FETCH;   // HELD: skid contents are dropped
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_skid    <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      if (w_skid_we) r_skid <= ImemRData;
    end
  end

  // The loaded PC is always the current PCF: PCF only advances on a load.
  always_comb begin
    w_ifid_d.instr   = w_load_instr;
    w_ifid_d.pc      = r_pc;
    w_ifid_d.pcplus4 = w_pc_plus4;
  end

  fetchff #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (StallD),
    .i_flush (FlushD),
    .i_load  (w_load),
    .i_data  (w_ifid_d),
    .o_q     (w_ifid_q),
    .o_valid (ValidD)
  );

  assign InstrD   = w_ifid_q.instr;
  assign PCD      = w_ifid_q.pc;
  assign PCPlus4D = w_ifid_q.pcplus4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq, ImemValid;
  logic [31:0] ImemAddr, ImemRData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;

  ifid_t       exp_q[$];    // expected IF/ID loads, in order
  logic [31:0] req_q[$];    // expected request addresses, in order

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemValid(ImemValid), .ImemRData(ImemRData), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8093;
      32'h8:   return 32'h00A0_0113;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  function automatic ifid_t mk(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
    ifid_t t;
    t.instr = i; t.pc = p; t.pcplus4 = p4;
    return t;
  endfunction

  // Memory model: latches requests seen at the edge, answers mem_lat cycles
  // later for one cycle; also checks request addresses against req_q.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  initial begin
    ImemValid = 1'b0;
    ImemRData = 32'h0;
  end
  always begin
    logic        r;
    logic [31:0] a;
    @(posedge clk);
    r = ImemReq;
    a = ImemAddr;
    #1;
    ImemValid = 1'b0;
    if (r) begin
      chk("single_outstanding", {31'b0, pend}, 32'h0);
      if (req_q.size() == 0) chk("req_unexpected", {31'b0, r}, 32'h0);
      else chk("req_addr", a, req_q.pop_front());
      pend = 1'b1; cnt = mem_lat; paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        ImemValid = 1'b1;
        ImemRData = memword(paddr);
        pend = 1'b0;
      end
    end
  end

  // IF/ID monitor: a new value is expected unless the last edge held it.
  ifid_t exp_cur;
  logic  exp_v;
  initial begin
    exp_cur = ifid_bubble(NOP_INSTR_C);
    exp_v   = 1'b0;
    forever begin
      logic hl;
      @(posedge clk);
      hl = rst_n && StallD && !FlushD;
      @(negedge clk);
      if (!hl) begin
        if (ValidD) begin
          if (exp_q.size() == 0) begin
            chk("ifid_unexpected", {31'b0, ValidD}, 32'h0);
            exp_cur = mk(InstrD, PCD, PCPlus4D);
          end else begin
            exp_cur = exp_q.pop_front();
          end
          exp_v = 1'b1;
        end else begin
          exp_cur = ifid_bubble(NOP_INSTR_C);
          exp_v   = 1'b0;
        end
      end
      chk("ValidD", {31'b0, ValidD}, {31'b0, exp_v});
      chk("InstrD", InstrD, exp_cur.instr);
      chk("PCD", PCD, exp_cur.pc);
      chk("PCPlus4D", PCPlus4D, exp_cur.pcplus4);
    end
  end

  task automatic fetch_one(input int l);
    mem_lat = l;
    StallF = 1'b0;
    @(negedge clk);
    StallF = 1'b1;
    repeat (l + 1) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, ImemReq}, 32'h0);
    chk("rst_addr", ImemAddr, 32'h0);

    // 1-cycle memory, no stalls
    req_q.push_back(32'h0);
    exp_q.push_back(mk(32'h0050_0093, 32'h0, 32'h4));
    rst_n = 1'b1;
    fetch_one(1);
    chk("t1_next_addr", ImemAddr, 32'h4);

    // 3-cycle latency: no request and bubbles while waiting
    req_q.push_back(32'h4);
    exp_q.push_back(mk(32'h0010_8093, 32'h4, 32'h8));
    mem_lat = 3; StallF = 1'b0;
    @(negedge clk);
    StallF = 1'b1;
    chk("t2_wait_req", {31'b0, ImemReq}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("t2_wait_req", {31'b0, ImemReq}, 32'h0);
      chk("t2_wait_valid", {31'b0, ValidD}, 32'h0);
    end
    @(negedge clk);                       // load has happened

    // StallD for 4 edges while the response lands in the skid buffer
    req_q.push_back(32'h8);
    exp_q.push_back(mk(32'h00A0_0113, 32'h8, 32'hC));
    StallD = 1'b1; StallF = 1'b0; mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_held_req", {31'b0, ImemReq}, 32'h0);
    chk("t3_held_addr", ImemAddr, 32'h8);
    @(negedge clk);
    @(negedge clk);
    StallD = 1'b0; StallF = 1'b1;
    @(negedge clk);
    chk("t3_next_addr", ImemAddr, 32'hC);

    // Redirect while waiting, plus flush over a stalled valid IF/ID
    req_q.push_back(32'hC);
    StallD = 1'b1; StallF = 1'b0; mem_lat = 3;
    @(negedge clk);
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0102; FlushD = 1'b1;
    @(negedge clk);
    PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    chk("t4_redir_addr", ImemAddr, 32'h100);
    chk("t4_wait_req", {31'b0, ImemReq}, 32'h0);
    repeat (3) @(negedge clk);

    // Redirect coincident with the response
    req_q.push_back(32'h100);
    mem_lat = 1; StallF = 1'b0;
    @(negedge clk);
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
    @(negedge clk);
    PCSrcE = 1'b0;
    chk("t5a_addr", ImemAddr, 32'h200);
    @(negedge clk);

    // Redirect while HELD
    req_q.push_back(32'h200);
    StallF = 1'b0; StallD = 1'b1;
    @(negedge clk);
    StallF = 1'b1;
    @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    @(negedge clk);
    PCSrcE = 1'b0; StallD = 1'b0;
    chk("t5b_addr", ImemAddr, 32'h300);
    @(negedge clk);
    req_q.push_back(32'h300);
    exp_q.push_back(mk(32'hC0DE_0300, 32'h300, 32'h304));
    fetch_one(1);
    chk("t5b_next_addr", ImemAddr, 32'h304);

    // PC wrap at the top of the address space (target also unaligned)
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    @(negedge clk);
    PCSrcE = 1'b0;
    chk("t6_addr", ImemAddr, 32'hFFFF_FFFC);
    req_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(mk(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0));
    fetch_one(1);
    chk("t6_wrap_addr", ImemAddr, 32'h0);

    // Reset during WAIT; the late response must be ignored
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    @(negedge clk);
    PCSrcE = 1'b0;
    req_q.push_back(32'h40);
    mem_lat = 4; StallF = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_req", {31'b0, ImemReq}, 32'h0);
    chk("t7_rst_addr", ImemAddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; StallF = 1'b1;
    repeat (4) @(negedge clk);
    req_q.push_back(32'h0);
    exp_q.push_back(mk(32'h0050_0093, 32'h0, 32'h4));
    fetch_one(1);
    chk("t7_next_addr", ImemAddr, 32'h4);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'h0);
    chk("req_q_empty", req_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline: PC register, next-PC selection, instruction-memory request/response handshake, skid buffer and IF/ID pipeline register.
- Produces InstrD/PCD/PCPlus4D for the decoder, whose outputs feed the ID/EX register.
- Takes StallF/StallD/FlushD from the hazard unit and PCSrcE/PCTargetE from execute.
- Tolerates variable-latency instruction memory with one outstanding request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding inserted into IF/ID on bubble/flush (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
StallF  input  1  hazard unit: suppress new fetch request
StallD  input  1  hazard unit: hold IF/ID register
FlushD  input  1  hazard unit: clear IF/ID to bubble
PCSrcE  input  1  execute: redirect fetch to PCTargetE
PCTargetE  input  32  execute: branch/jump target
ImemReq  output  1  request valid to instruction memory
ImemAddr  output  32  request address (= PCF)
ImemValid  input  1  response valid, >=1 cycle after request
ImemRData  input  32  response instruction word
InstrD  output  32  IF/ID instruction
PCD  output  32  IF/ID PC
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  1 = InstrD is a real instruction, 0 = bubble

Behaviour:
- Reset (rst_n=0 at posedge): PCF<=RESET_PC, state<=FETCH, discard<=0, InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0, skid cleared. ImemReq=0 while rst_n=0.
- ImemReq = (state==FETCH) && !StallF && rst_n (combinational). ImemAddr=PCF at all times. Memory accepts every asserted request.
- States:
  - FETCH: if ImemReq -> WAIT; else stay.
  - WAIT, ImemValid=1, discard=1: drop response, discard<=0 -> FETCH.
  - WAIT, ImemValid=1, discard=0, StallD=0: IF/ID <= {ImemRData, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4 -> FETCH.
  - WAIT, ImemValid=1, discard=0, StallD=1: skid <= ImemRData -> HELD.
  - HELD, StallD=0: IF/ID <= {skid, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4 -> FETCH.
- Bubbles: if StallD=0 and no load occurs this cycle, IF/ID <= {NOP_INSTR, 0, 0}, ValidD<=0. If StallD=1, IF/ID holds.
- Latency: best case (1-cycle memory, no stalls) is one instruction per 2 cycles (req cycle, response cycle). Request-to-IF/ID is one edge after ImemValid.
- Redirect (PCSrcE=1) overrides FSM actions:
  - PCF <= {PCTargetE[31:2],2'b00}.
  - FETCH with request issued this cycle: discard<=1 -> WAIT.
  - FETCH with no request: stay FETCH.
  - WAIT, ImemValid=0: discard<=1, stay WAIT.
  - WAIT, ImemValid=1: drop response -> FETCH.
  - HELD: drop skid -> FETCH.
  - No IF/ID load from a redirected path.
- FlushD=1: IF/ID <= bubble. Overrides StallD and any load. Does not affect PCF or the FSM.
- Priority: rst_n > PCSrcE (PC/FSM) > FlushD (IF/ID) > StallD > load.
- Arithmetic: PCF+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Reset mid-WAIT: state returns to FETCH, discard cleared. Any late ImemValid arriving in FETCH is ignored.

Decomposition:
- Shared package pipeline_pkg: NOP_INSTR constant, fetch state enum {FETCH, WAIT, HELD}, RESET_PC default.
- One sub-module, fetchff: the IF/ID register with stall/flush/load controls and reset. FSM, PC and skid stay in fetch_stage.

Test Plan:
- Reset then 1-cycle memory returning 0x00500093 at addr 0, no stalls -> ImemReq@0, InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1 one edge after ImemValid; next ImemAddr=4.
- 3-cycle memory latency -> ValidD=0/NOP_INSTR for the waiting cycles; single request outstanding; ImemReq low in WAIT.
- StallD=1 for 4 cycles as response 0x00A00113 arrives -> IF/ID unchanged, data held in skid (HELD); on StallD=0, InstrD=0x00A00113, ValidD=1, PCF advances by 4 exactly once.
- PCSrcE=1, PCTargetE=0x0000_0102 while in WAIT, plus FlushD=1 -> next ImemAddr=0x100; stale response discarded (never appears on InstrD); IF/ID bubble.
- Redirect coincident with ImemValid, and with state HELD -> response/skid dropped, next request at target, no spurious ValidD=1.
- PC at 0xFFFF_FFFC fetched -> PCPlus4D=0, next ImemAddr=0. rst_n=0 during WAIT -> outputs return to reset values, next request at RESET_PC.
